// File: rtl/topk_pkg.sv
// Shared helpers for the top-K tracker.
//   rank_w / count_w : port widths derived from the depth K
//   gt               : ordering used for every slot compare. Operands arrive already extended
//                      to MaxDataW by the caller (sign-extended in signed builds).
// Build option: TOPK_SIGNED_EN selects two's-complement ordering; default is unsigned.
package topk_pkg;

    // Widest sample the compare helper accepts.
    localparam int unsigned MaxDataW = 256;

    function automatic int unsigned rank_w(input int unsigned k);
        return $clog2(k);
    endfunction

    function automatic int unsigned count_w(input int unsigned k);
        return $clog2(k + 1);
    endfunction

    function automatic logic gt(input logic [MaxDataW-1:0] a, input logic [MaxDataW-1:0] b);
`ifdef TOPK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

endpackage

// File: rtl/topk_slot_cell.sv
// One slot of the sorted top-K array.
//   clk, resetn       : clock, asynchronous active-low reset
//   clear, din_valid  : flush / sample qualifier shared by all slots
//   din               : incoming sample
//   upper_val/ins     : value and insert flag of the slot one rank above
//   occupied          : this slot currently holds a tracked entry
//   slot_val          : registered slot contents
//   ins               : din belongs at or above this rank (empty slot, or din > slot_val)
// The ins flags form a thermometer down the array; the first set flag is the insert
// position, slots below it take their upper neighbour.
// Build option: TOPK_SIGNED_EN selects sign extension ahead of the compare.
module topk_slot_cell
    import topk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          IS_FIRST   = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] upper_val,
    input  logic                  upper_ins,
    input  logic                  occupied,
    output logic [DATA_WIDTH-1:0] slot_val,
    output logic                  ins
);

    logic [DATA_WIDTH-1:0] slot_q, slot_d;
    logic [MaxDataW-1:0]   din_x, own_x;

`ifdef TOPK_SIGNED_EN
    assign din_x = MaxDataW'($signed(din));
    assign own_x = MaxDataW'($signed(slot_q));
`else
    assign din_x = MaxDataW'(din);
    assign own_x = MaxDataW'(slot_q);
`endif

    // Strict compare keeps equal entries ahead of din, so duplicates stay in arrival order.
    assign ins = !occupied || gt(din_x, own_x);

    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            // A sample arriving with clear becomes the sole entry.
            slot_d = (IS_FIRST && din_valid) ? din : '0;
        end else if (din_valid && ins) begin
            slot_d = upper_ins ? upper_val : din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_val = slot_q;

endmodule

// File: rtl/topk_tracker.sv
// Streaming tracker of the K largest samples since reset or clear, sorted descending.
//   clk, resetn  : clock, asynchronous active-low reset
//   clear        : synchronous flush of the tracked set and counters
//   din_valid    : din carries a sample this cycle (never back-pressured)
//   din          : sample value
//   rank_sel     : rank to read, 0 = largest
//   dout         : slot value at rank_sel, 0 when rank_sel >= count
//   dout_valid   : rank_sel < count
//   count        : occupied slots, saturates at K
//   samples      : accepted samples since clear, saturates at all-ones
// Build option: TOPK_SIGNED_EN switches every compare to two's-complement.
module topk_tracker
    import topk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K          = 4,
    parameter int unsigned SAMP_W     = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    din_valid,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [rank_w(K)-1:0]    rank_sel,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic [count_w(K)-1:0]   count,
    output logic [SAMP_W-1:0]       samples
);

    localparam int unsigned RankW  = rank_w(K);
    localparam int unsigned CountW = count_w(K);

    logic [DATA_WIDTH-1:0] slot_val [K];
    logic [K-1:0]          ins;
    logic [K-1:0]          occupied;

    logic [CountW-1:0] count_q, count_d;
    logic [SAMP_W-1:0] samples_q, samples_d;

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic [DATA_WIDTH-1:0] up_val;
        logic                  up_ins;

        if (i == 0) begin : g_first
            assign up_val = '0;
            assign up_ins = 1'b0;
        end else begin : g_rest
            assign up_val = slot_val[i-1];
            assign up_ins = ins[i-1];
        end

        assign occupied[i] = count_q > CountW'(i);

        topk_slot_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .IS_FIRST   (i == 0)
        ) u_cell (
            .clk       (clk),
            .resetn    (resetn),
            .clear     (clear),
            .din_valid (din_valid),
            .din       (din),
            .upper_val (up_val),
            .upper_ins (up_ins),
            .occupied  (occupied[i]),
            .slot_val  (slot_val[i]),
            .ins       (ins[i])
        );
    end

    always_comb begin
        count_d   = count_q;
        samples_d = samples_q;
        if (clear) begin
            count_d   = din_valid ? CountW'(1) : '0;
            samples_d = din_valid ? SAMP_W'(1) : '0;
        end else if (din_valid) begin
            if (count_q != CountW'(K)) begin
                count_d = count_q + CountW'(1);
            end
            if (!(&samples_q)) begin
                samples_d = samples_q + SAMP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            samples_q <= '0;
        end else begin
            count_q   <= count_d;
            samples_q <= samples_d;
        end
    end

    // Loop mux avoids indexing past K-1 when K is not a power of two.
    always_comb begin
        dout       = '0;
        dout_valid = CountW'(rank_sel) < count_q;
        for (int unsigned i = 0; i < K; i++) begin
            if (dout_valid && (RankW'(i) == rank_sel)) begin
                dout = slot_val[i];
            end
        end
    end

    assign count   = count_q;
    assign samples = samples_q;

endmodule

// File: tb/tb_topk_tracker.sv
module tb_topk_tracker;

    localparam int K = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear;
    logic        din_valid;
    logic [31:0] din;
    logic [1:0]  rank_sel;
    logic [31:0] dout, dout2;
    logic        dout_valid, dout_valid2;
    logic [2:0]  count, count2;
    logic [15:0] samples;
    logic [3:0]  samples2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    topk_tracker #(.DATA_WIDTH(32), .K(K), .SAMP_W(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .din_valid  (din_valid),
        .din        (din),
        .rank_sel   (rank_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .samples    (samples)
    );

    // Narrow sample counter to exercise saturation.
    topk_tracker #(.DATA_WIDTH(32), .K(K), .SAMP_W(4)) dut_s4 (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .din_valid  (din_valid),
        .din        (din),
        .rank_sel   (rank_sel),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .count      (count2),
        .samples    (samples2)
    );

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int          m_samp;
    int          m_samp4;

    function automatic bit m_gt(input logic [31:0] a, input logic [31:0] b);
`ifdef TOPK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic model_step(input logic c, input logic v, input logic [31:0] d);
        int pos;
        if (c) begin
            mq.delete();
            m_samp  = 0;
            m_samp4 = 0;
            if (v) begin
                mq.push_back(d);
                m_samp  = 1;
                m_samp4 = 1;
            end
        end else if (v) begin
            if (m_samp < 65535) m_samp++;
            if (m_samp4 < 15) m_samp4++;
            if (mq.size() < K || m_gt(d, mq[mq.size()-1])) begin
                pos = 0;
                while (pos < mq.size() && !m_gt(d, mq[pos])) pos++;
                mq.insert(pos, d);
                if (mq.size() > K) void'(mq.pop_back());
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_samp  = 0;
        m_samp4 = 0;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [31:0] d);
        clear = c;
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
        clear = 1'b0;
        din_valid = 1'b0;
        model_step(c, v, d);
    endtask

    // Compare every rank plus counters against explicit expectations.
    task automatic check_state(input string tag, input logic [3:0][31:0] s, input int cnt,
                               input int samp);
        check({tag, " count"}, 64'(count), 64'(cnt));
        check({tag, " samples"}, 64'(samples), 64'(samp));
        for (int r = 0; r < K; r++) begin
            rank_sel = 2'(r);
            #1;
            check($sformatf("%s dout r%0d", tag, r), 64'(dout), (r < cnt) ? 64'(s[r]) : 64'd0);
            check($sformatf("%s dvalid r%0d", tag, r), 64'(dout_valid), 64'(r < cnt));
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0][31:0] s;
        s = '0;
        for (int i = 0; i < mq.size(); i++) s[i] = mq[i];
        check_state(tag, s, mq.size(), m_samp);
        check({tag, " samples4"}, 64'(samples2), 64'(m_samp4));
        check({tag, " count4"}, 64'(count2), 64'(mq.size()));
        check({tag, " dout4"}, 64'(dout2), 64'(dout));
    endtask

    typedef struct {
        logic             c;
        logic             v;
        logic [31:0]      d;
        logic [3:0][31:0] s;
        int               cnt;
        int               samp;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic v, input logic [31:0] d,
                                input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input int cnt, input int samp);
        vec_t t;
        t.c = c; t.v = v; t.d = d;
        t.s = {s3, s2, s1, s0};
        t.cnt = cnt; t.samp = samp;
        return t;
    endfunction

    vec_t tbl [13];

    initial begin
        tbl[0]  = mk(0, 1, 5,   5, 0, 0, 0, 1, 1);
        tbl[1]  = mk(0, 1, 9,   9, 5, 0, 0, 2, 2);
        tbl[2]  = mk(0, 1, 2,   9, 5, 2, 0, 3, 3);
        tbl[3]  = mk(0, 1, 7,   9, 7, 5, 2, 4, 4);
        tbl[4]  = mk(0, 1, 1,   9, 7, 5, 2, 4, 5);
        tbl[5]  = mk(0, 1, 8,   9, 8, 7, 5, 4, 6);
        tbl[6]  = mk(0, 1, 5,   9, 8, 7, 5, 4, 7);
        tbl[7]  = mk(0, 0, 100, 9, 8, 7, 5, 4, 7);
        tbl[8]  = mk(1, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 9,   9, 0, 0, 0, 1, 1);
        tbl[10] = mk(0, 1, 9,   9, 9, 0, 0, 2, 2);
        tbl[11] = mk(0, 1, 9,   9, 9, 9, 0, 3, 3);
        tbl[12] = mk(1, 1, 3,   3, 0, 0, 0, 1, 1);

        resetn = 1'b0;
        clear = 1'b0;
        din_valid = 1'b0;
        din = '0;
        rank_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("reset", '0, 0, 0);
        resetn = 1'b1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].c, tbl[i].v, tbl[i].d);
            check_state($sformatf("vec%0d", i), tbl[i].s, tbl[i].cnt, tbl[i].samp);
        end

        // Async reset mid-stream, no clock edge in between.
        step(0, 1, 40);
        step(0, 1, 41);
        rank_sel = 2'd0;
        #1 resetn = 1'b0;
        #1;
        check("async dout", 64'(dout), 64'd0);
        check("async dvalid", 64'(dout_valid), 64'd0);
        check("async count", 64'(count), 64'd0);
        check("async samples", 64'(samples), 64'd0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;

        // Sign-sensitive ordering.
        step(0, 1, 32'hFFFF_FFFF);
        step(0, 1, 32'd1);
        rank_sel = 2'd0;
        #1;
`ifdef TOPK_SIGNED_EN
        check("sign r0", 64'(dout), 64'd1);
`else
        check("sign r0", 64'(dout), 64'hFFFF_FFFF);
`endif
        check_model("sign");

        // Sample counter saturation on the 4-bit instance.
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 32'(i * 3));
        check("sat samples4", 64'(samples2), 64'd15);
        check("sat samples16", 64'(samples), 64'd20);
        check_model("sat");

        // Randomized stream against the model.
        for (int n = 0; n < 400; n++) begin
            logic        c, v;
            logic [31:0] d;
            c = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            step(c, v, d);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
